// File: rtl/envelope_pulse_capture.sv
// envelope_pulse_capture
// Frames each envelope pulse on one TS4231 sensor channel. For every pulse it
// records the start timestamp, the length in cycles, and the data bits sampled
// while the envelope was high (two per cycle). It then offers the result as one
// record to the pulse decoder.
//
// Output handshake (valid/ready):
//   A record transfers on a rising clk_96MHz edge where out_valid & out_ready.
//   Once out_valid is raised, it and every out_* field stay unchanged until that
//   transfer. out_valid drops on the cycle after the transfer, unless a new
//   record is loaded on the same edge. The consumer may hold out_ready at any
//   level; out_valid never depends combinationally on out_ready.
module envelope_pulse_capture #(
   parameter int DATA_W  = 64,
   parameter int TS_W    = 32,
   parameter int LEN_W   = 16,
   parameter int MIN_LEN = 4
) (
   input  logic                        clk_96MHz,
   input  logic                        rst_n,
   input  logic                        e_in,
   input  logic                        d_in_0,
   input  logic                        d_in_1,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [TS_W-1:0]             out_timestamp,
   output logic [LEN_W-1:0]            out_length,
   output logic [$clog2(DATA_W+1)-1:0] out_nbits,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_trunc,
   output logic [7:0]                  dropped_count
);

   localparam int               NB_W      = $clog2(DATA_W+1);
   localparam logic [LEN_W-1:0] LEN_MAX   = '1;
   localparam logic [LEN_W-1:0] LEN_MIN_L = LEN_W'(MIN_LEN);
   localparam logic [NB_W-1:0]  NB_FULL   = NB_W'(DATA_W);

   typedef enum logic {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [TS_W-1:0]   ts_cnt;
   logic              e_prev;
   logic              rise, fall;
   logic              cap_start, cap_finish;
   logic              len_ok, slot_free, rec_load, rec_drop;

   logic [TS_W-1:0]   cap_ts;
   logic [LEN_W-1:0]  cap_len;
   logic [DATA_W-1:0] cap_shift;
   logic [NB_W-1:0]   cap_nbits;
   logic              cap_trunc;

   assign rise = e_in & ~e_prev;
   assign fall = ~e_in & e_prev;

   // Free-running timestamp and one-cycle envelope history for edge detection
   always_ff @(posedge clk_96MHz or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt <= '0;
         e_prev <= 1'b0;
      end else begin
         ts_cnt <= ts_cnt + TS_W'(1);
         e_prev <= e_in;
      end
   end

   // FSM state register
   always_ff @(posedge clk_96MHz or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state plus start/finish strobes that steer the capture and output slot
   always_comb begin
      state_d    = state_q;
      cap_start  = 1'b0;
      cap_finish = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d   = CAPTURE;
               cap_start = 1'b1;
            end
         end
         CAPTURE: begin
            if (fall) begin
               state_d    = IDLE;
               cap_finish = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A finished pulse either loads the slot, is lost because the slot is busy,
   // or is too short to report. A record accepted on this edge frees the slot.
   always_comb begin
      len_ok    = (cap_len >= LEN_MIN_L);
      slot_free = ~out_valid | out_ready;
      rec_load  = cap_finish & len_ok & slot_free;
      rec_drop  = cap_finish & len_ok & ~slot_free;
   end

   // Capture datapath: the first bits end up at the top, the newest bits at bit 0
   always_ff @(posedge clk_96MHz or negedge rst_n) begin
      if (!rst_n) begin
         cap_ts    <= '0;
         cap_len   <= '0;
         cap_shift <= '0;
         cap_nbits <= '0;
         cap_trunc <= 1'b0;
      end else if (cap_start) begin
         cap_ts    <= ts_cnt;
         cap_len   <= LEN_W'(1);
         cap_shift <= DATA_W'({d_in_1, d_in_0});
         cap_nbits <= NB_W'(2);
         cap_trunc <= 1'b0;
      end else if (state_q == CAPTURE && e_in) begin
         if (cap_len != LEN_MAX) cap_len <= cap_len + LEN_W'(1);
         if (cap_nbits < NB_FULL) begin
            cap_shift <= (cap_shift << 2) | DATA_W'({d_in_1, d_in_0});
            cap_nbits <= cap_nbits + NB_W'(2);
         end else begin
            cap_trunc <= 1'b1;
         end
      end
   end

   // Single-entry output slot, held stable until the consumer takes it
   always_ff @(posedge clk_96MHz or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_timestamp <= '0;
         out_length    <= '0;
         out_nbits     <= '0;
         out_data      <= '0;
         out_trunc     <= 1'b0;
      end else if (rec_load) begin
         out_valid     <= 1'b1;
         out_timestamp <= cap_ts;
         out_length    <= cap_len;
         out_nbits     <= cap_nbits;
         out_data      <= cap_shift;
         out_trunc     <= cap_trunc;
      end else if (out_valid && out_ready) begin
         out_valid     <= 1'b0;
      end
   end

   // Saturating count of records lost to a busy output slot
   always_ff @(posedge clk_96MHz or negedge rst_n) begin
      if (!rst_n)                               dropped_count <= 8'd0;
      else if (rec_drop && dropped_count != 8'hFF) dropped_count <= dropped_count + 8'd1;
   end

endmodule

// File: tb/tb_envelope_pulse_capture.sv
// Testbench for envelope_pulse_capture. Directed scenarios are checked against
// constants. A random pulse train is checked against a pulse-level reference
// model that keeps the captured bits in a queue.
module tb_envelope_pulse_capture;

   localparam int DATA_W  = 64;
   localparam int TS_W    = 32;
   localparam int LEN_W   = 16;
   localparam int MIN_LEN = 4;
   localparam int NB_W    = $clog2(DATA_W+1);
   localparam int REC_W   = TS_W + LEN_W + NB_W + DATA_W + 1;

   // ---------------- clock / reset ----------------
   logic clk_96MHz = 1'b0;
   always #5 clk_96MHz = ~clk_96MHz;

   logic rst_n = 1'b0;
   logic e_in = 1'b0, d_in_0 = 1'b0, d_in_1 = 1'b0, out_ready = 1'b0;

   logic                out_valid;
   logic [TS_W-1:0]     out_timestamp;
   logic [LEN_W-1:0]    out_length;
   logic [NB_W-1:0]     out_nbits;
   logic [DATA_W-1:0]   out_data;
   logic                out_trunc;
   logic [7:0]          dropped_count;

   logic                w8_valid;
   logic [7:0]          w8_ts;
   logic [LEN_W-1:0]    w8_len;
   logic [NB_W-1:0]     w8_nbits;
   logic [DATA_W-1:0]   w8_data;
   logic                w8_trunc;
   logic [7:0]          w8_drop;

   envelope_pulse_capture #(
      .DATA_W(DATA_W), .TS_W(TS_W), .LEN_W(LEN_W), .MIN_LEN(MIN_LEN)
   ) dut (
      .clk_96MHz(clk_96MHz), .rst_n(rst_n), .e_in(e_in), .d_in_0(d_in_0), .d_in_1(d_in_1),
      .out_valid(out_valid), .out_ready(out_ready), .out_timestamp(out_timestamp),
      .out_length(out_length), .out_nbits(out_nbits), .out_data(out_data),
      .out_trunc(out_trunc), .dropped_count(dropped_count)
   );

   // Narrow-timestamp instance, used to observe counter wrap
   envelope_pulse_capture #(
      .DATA_W(DATA_W), .TS_W(8), .LEN_W(LEN_W), .MIN_LEN(MIN_LEN)
   ) dut8 (
      .clk_96MHz(clk_96MHz), .rst_n(rst_n), .e_in(e_in), .d_in_0(d_in_0), .d_in_1(d_in_1),
      .out_valid(w8_valid), .out_ready(out_ready), .out_timestamp(w8_ts),
      .out_length(w8_len), .out_nbits(w8_nbits), .out_data(w8_data),
      .out_trunc(w8_trunc), .dropped_count(w8_drop)
   );

   wire [REC_W-1:0] dut_rec = {out_timestamp, out_length, out_nbits, out_data, out_trunc};

   int checks = 0;
   int errors = 0;
   logic [31:0] cyc;

   // ---------------- reference model ----------------
   logic [REC_W-1:0] exp_q[$];
   bit               m_bits[$];
   logic             m_prev, m_in, m_valid, m_trunc;
   logic [TS_W-1:0]  m_start;
   int               m_len;
   int               m_drop;

   function automatic logic [REC_W-1:0] make_rec(input logic [TS_W-1:0] ts, input int len,
                                                 input int nb, input logic [DATA_W-1:0] d,
                                                 input logic tr);
      return {ts, LEN_W'(len), NB_W'(nb), d, tr};
   endfunction

   function automatic logic [REC_W-1:0] model_record();
      logic [DATA_W-1:0] d;
      d = '0;
      foreach (m_bits[i]) d = {d[DATA_W-2:0], m_bits[i]};
      return make_rec(m_start, m_len, m_bits.size(), d, m_trunc);
   endfunction

   // ---------------- driver ----------------
   task automatic do_reset(input logic e_hold);
      rst_n = 1'b0; e_in = e_hold; d_in_0 = 1'b0; d_in_1 = 1'b0;
      repeat (2) @(posedge clk_96MHz);
      #1 rst_n = 1'b1;
      cyc = 0;
      m_prev = 1'b0; m_in = 1'b0; m_valid = 1'b0; m_trunc = 1'b0;
      m_len = 0; m_drop = 0; m_start = '0;
      exp_q.delete(); m_bits.delete();
   endtask

   // One clock: apply inputs, advance the reference model, return 1 time unit after the edge
   task automatic tick(input logic e, input logic d1, input logic d0, input logic rdy);
      e_in = e; d_in_1 = d1; d_in_0 = d0; out_ready = rdy;
      @(posedge clk_96MHz);
      if (m_valid && rdy) begin
         void'(exp_q.pop_front());
         m_valid = 1'b0;
      end
      if (!e && m_prev && m_in) begin
         m_in = 1'b0;
         if (m_len >= MIN_LEN) begin
            if (!m_valid) begin
               exp_q.push_back(model_record());
               m_valid = 1'b1;
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end
      end else if (e && m_in) begin
         if (m_len < (1 << LEN_W) - 1) m_len++;
         if (m_bits.size() < DATA_W) begin
            m_bits.push_back(d1);
            m_bits.push_back(d0);
         end else begin
            m_trunc = 1'b1;
         end
      end
      if (e && !m_prev) begin
         m_in = 1'b1; m_start = cyc; m_len = 1; m_trunc = 1'b0;
         m_bits.delete();
         m_bits.push_back(d1);
         m_bits.push_back(d0);
      end
      m_prev = e;
      cyc++;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; e_in = 1'b1; out_ready = 1'b1;
      repeat (3) @(posedge clk_96MHz);
      #1;
      checks++;
      if (out_valid !== 1'b0 || dropped_count !== 8'd0)
         $display("FAIL reset_ctrl: valid=%b dropped=%0d expected 0/0", out_valid, dropped_count);
      checks++;
      if (dut_rec !== '0)
         $display("FAIL reset_rec: got %h expected 0", dut_rec);
      if (out_valid !== 1'b0 || dropped_count !== 8'd0 || dut_rec !== '0) errors++;
   endtask

   task automatic test_basic();
      do_reset(1'b0);
      repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (10) tick(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_early: valid=%b expected 0", out_valid);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL basic_valid: valid=%b expected 1", out_valid);
      end
      checks++;
      if (dut_rec !== make_rec(32'd10, 10, 20, 64'hAAAAA, 1'b0)) begin
         errors++;
         $display("FAIL basic_rec: got %h expected %h", dut_rec, make_rec(32'd10, 10, 20, 64'hAAAAA, 1'b0));
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_oneshot: valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_short();
      do_reset(1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) tick(1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b1);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL short_valid: cycle %0d valid=%b expected 0", i, out_valid);
         end
      end
      checks++;
      if (dropped_count !== 8'd0) begin
         errors++; $display("FAIL short_drop: got %0d expected 0", dropped_count);
      end
   endtask

   task automatic test_trunc();
      logic [DATA_W-1:0] exp_d;
      logic b1, b0;
      exp_d = '0;
      do_reset(1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) begin
         b1 = 1'($urandom_range(0, 1));
         b0 = 1'($urandom_range(0, 1));
         if (i < DATA_W / 2) exp_d = {exp_d[DATA_W-3:0], b1, b0};
         tick(1'b1, b1, b0, 1'b1);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || dut_rec !== make_rec(32'd2, 40, 64, exp_d, 1'b1)) begin
         errors++;
         $display("FAIL trunc_rec: valid=%b got %h expected %h", out_valid, dut_rec,
                  make_rec(32'd2, 40, 64, exp_d, 1'b1));
      end
   endtask

   task automatic test_back_to_back();
      logic [REC_W-1:0] rec_a;
      rec_a = make_rec(32'd2, 5, 10, 64'h3FF, 1'b0);
      do_reset(1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (5) tick(1'b1, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || dut_rec !== rec_a) begin
         errors++; $display("FAIL b2b_first: valid=%b got %h expected %h", out_valid, dut_rec, rec_a);
      end
      for (int i = 0; i < 6; i++) begin
         tick(i < 5, 1'b0, 1'b0, 1'b0);
         checks++;
         if (out_valid !== 1'b1 || dut_rec !== rec_a) begin
            errors++; $display("FAIL b2b_hold: cycle %0d valid=%b got %h expected %h", i, out_valid, dut_rec, rec_a);
         end
      end
      checks++;
      if (dropped_count !== 8'd1) begin
         errors++; $display("FAIL b2b_drop: got %0d expected 1", dropped_count);
      end
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b1);
         checks++;
         if (out_valid !== 1'b0 || dropped_count !== 8'd1) begin
            errors++; $display("FAIL b2b_release: cycle %0d valid=%b dropped=%0d expected 0/1", i, out_valid, dropped_count);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dropped_count !== 8'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset: dropped=%0d valid=%b expected 0/0", dropped_count, out_valid);
      end
   endtask

   task automatic test_accept_same_cycle();
      logic [REC_W-1:0] rec_a, rec_b;
      rec_a = make_rec(32'd2, 4, 8, 64'h55, 1'b0);
      rec_b = make_rec(32'd8, 6, 12, 64'hAAA, 1'b0);
      do_reset(1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) tick(1'b1, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || dut_rec !== rec_a) begin
         errors++; $display("FAIL minlen_rec: valid=%b got %h expected %h", out_valid, dut_rec, rec_a);
      end
      repeat (6) tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || dut_rec !== rec_b) begin
         errors++; $display("FAIL replace_rec: valid=%b got %h expected %h", out_valid, dut_rec, rec_b);
      end
      checks++;
      if (dropped_count !== 8'd0) begin
         errors++; $display("FAIL replace_drop: got %0d expected 0", dropped_count);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL replace_done: valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_pulse();
      do_reset(1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b1);
      do_reset(1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL midreset_abandon: valid=%b expected 0", out_valid);
      end
      repeat (5) tick(1'b1, 1'b1, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || dut_rec !== make_rec(32'd0, 5, 10, 64'h3FF, 1'b0)) begin
         errors++;
         $display("FAIL midreset_rec: valid=%b got %h expected %h", out_valid, dut_rec,
                  make_rec(32'd0, 5, 10, 64'h3FF, 1'b0));
      end
      while (cyc != 255) tick(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (w8_valid !== 1'b1 || w8_ts !== 8'd255 || out_timestamp !== 32'd255) begin
         errors++; $display("FAIL wrap_255: valid=%b ts8=%0d ts32=%0d expected 1/255/255", w8_valid, w8_ts, out_timestamp);
      end
      while (cyc != 512) tick(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (w8_valid !== 1'b1 || w8_ts !== 8'd0 || out_timestamp !== 32'd512) begin
         errors++; $display("FAIL wrap_0: valid=%b ts8=%0d ts32=%0d expected 1/0/512", w8_valid, w8_ts, out_timestamp);
      end
   endtask

   task automatic test_random();
      int gap, len, thr;
      logic e, rdy;
      do_reset(1'b0);
      for (int p = 0; p <= 60; p++) begin
         gap = (p == 60) ? 6 : $urandom_range(1, 4);
         len = (p == 60) ? 0 : $urandom_range(1, 40);
         thr = (p == 60) ? 0 : $urandom_range(0, 3);
         for (int c = 0; c < gap + len; c++) begin
            e   = (c >= gap);
            rdy = ($urandom_range(0, 3) >= thr);
            tick(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy);
            checks++;
            if (out_valid !== m_valid || dropped_count !== 8'(m_drop)) begin
               errors++;
               $display("FAIL rand_ctrl: pulse %0d valid=%b dropped=%0d expected %b/%0d",
                        p, out_valid, dropped_count, m_valid, m_drop);
            end else if (m_valid) begin
               checks++;
               if (dut_rec !== exp_q[0]) begin
                  errors++;
                  $display("FAIL rand_rec: pulse %0d got %h expected %h", p, dut_rec, exp_q[0]);
               end
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_short();
      test_trunc();
      test_back_to_back();
      test_accept_same_cycle();
      test_reset_mid_pulse();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
